// File: rtl/gpr_pkg.sv
// Shared types, default widths and the byte-merge helper for the multiport GPR file.
package gpr_pkg;

    typedef enum logic {
        CLEARING,
        READY
    } gprState_e;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned FLAG_REG_DEF = 30;

    // byte_merge works on a fixed wide word; callers zero-extend and truncate.
    localparam int unsigned MERGE_W    = 256;
    localparam int unsigned MERGE_BE_W = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]    oldVal,
        input logic [MERGE_W-1:0]    newVal,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = oldVal;
        for (int unsigned i = 0; i < MERGE_BE_W; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = newVal[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gpr_clear_seq.sv
// Clear sequencer: sweeps entries 1..NUM_REGS-1 to zero after reset or on clr_req.
module gpr_clear_seq
    import gpr_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    gprState_e         state;
    gprState_e         stateNext;
    logic [ADDR_W-1:0] clrPtr;
    logic [ADDR_W-1:0] ptrNext;
    logic              busyNext;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= CLEARING;
            clrPtr <= ADDR_W'(1);
            busy   <= 1'b1;
        end else begin
            state  <= stateNext;
            clrPtr <= ptrNext;
            busy   <= busyNext;
        end
    end

    always_comb begin
        stateNext = state;
        ptrNext   = clrPtr;
        busyNext  = busy;
        clr_we    = 1'b0;
        clr_addr  = clrPtr;
        case (state)
            CLEARING: begin
                clr_we = 1'b1;
                if (clr_req) begin
                    ptrNext = ADDR_W'(1);
                end else if (clrPtr == '1) begin
                    stateNext = READY;
                    busyNext  = 1'b0;
                end else begin
                    ptrNext = clrPtr + ADDR_W'(1);
                end
            end
            READY: begin
                if (clr_req) begin
                    stateNext = CLEARING;
                    ptrNext   = ADDR_W'(1);
                    busyNext  = 1'b1;
                end
            end
            default: begin
                stateNext = CLEARING;
                ptrNext   = ADDR_W'(1);
                busyNext  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/gpr_multiport.sv
// Multiport GPR file: N combinational read ports, byte-enabled write, flag write, hardware clear.
// Define GPR_BYPASS_EN to forward same-cycle writes to matching read ports. DATA_W is limited to 256.
module gpr_multiport
    import gpr_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned FLAG_REG = FLAG_REG_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_write,
    input  logic [DATA_W/8-1:0]      byte_en,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     flag_write,
    input  logic                     clr_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     wr_dropped
);

    localparam int unsigned       NUM_REGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] FLAG_ADDR = ADDR_W'(FLAG_REG);

    function automatic logic [DATA_W-1:0] mergeWord(
        input logic [DATA_W-1:0]   oldVal,
        input logic [DATA_W-1:0]   newVal,
        input logic [DATA_W/8-1:0] be
    );
        return DATA_W'(byte_merge(MERGE_W'(oldVal), MERGE_W'(newVal), MERGE_BE_W'(be)));
    endfunction

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              clrWe;
    logic [ADDR_W-1:0] clrAddr;
    logic              mainWe;
    logic              flagWe;
    logic [DATA_W-1:0] wrMerged;

    gpr_clear_seq #(
        .ADDR_W(ADDR_W)
    ) uClearSeq (
        .clk     (clk),
        .reset   (reset),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (clrWe),
        .clr_addr(clrAddr)
    );

    always_comb begin
        mainWe   = reg_write && (write_addr != '0) && !busy;
        flagWe   = flag_write && (FLAG_ADDR != '0) && !busy;
        wrMerged = mergeWord(regs[write_addr], write_data, byte_en);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_dropped <= 1'b0;
        end else begin
            wr_dropped <= busy && (reg_write || flag_write);
        end
    end

    // Array has no reset of its own; the sweep zeroes it. The flag set follows the
    // main write so bit 0 wins when both target FLAG_REG in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (clrWe) begin
                regs[clrAddr] <= '0;
            end else begin
                if (mainWe) begin
                    regs[write_addr] <= wrMerged;
                end
                if (flagWe) begin
                    regs[FLAG_ADDR][0] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] rdA;
        logic [DATA_W-1:0] val;
        rd_data = '0;
        rdA     = '0;
        val     = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rdA = rd_addr[k*ADDR_W +: ADDR_W];
            val = regs[rdA];
`ifdef GPR_BYPASS_EN
            if (mainWe && (rdA == write_addr)) begin
                val = mergeWord(val, write_data, byte_en);
            end
            if (flagWe && (rdA == FLAG_ADDR)) begin
                val[0] = 1'b1;
            end
`endif
            if (busy || (rdA == '0)) begin
                val = '0;
            end
            rd_data[k*DATA_W +: DATA_W] = val;
        end
    end

endmodule

// File: tb/tb_gpr_multiport.sv
// Self-checking bench for gpr_multiport: directed steps followed by random traffic against a reference model.
module tb_gpr_multiport;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NREGS = 32;
    localparam int FLAGR = 30;

    logic           clk = 1'b0;
    logic           reset;
    logic           reg_write;
    logic [3:0]     byte_en;
    logic [4:0]     write_addr;
    logic [31:0]    write_data;
    logic           flag_write;
    logic           clr_req;
    logic [9:0]     rd_addr;
    logic [63:0]    rd_data;
    logic           busy;
    logic           wr_dropped;

    always #5 clk = ~clk;

    gpr_multiport #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_RD  (NR),
        .FLAG_REG(FLAGR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reg_write (reg_write),
        .byte_en   (byte_en),
        .write_addr(write_addr),
        .write_data(write_data),
        .flag_write(flag_write),
        .clr_req   (clr_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .wr_dropped(wr_dropped)
    );

    int          nChecks = 0;
    int          nPass   = 0;
    logic [31:0] mdl [NREGS];
    int          busyLeft = 0;
    logic        dropExp  = 1'b0;
    logic        known    = 1'b0;

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
        logic [31:0] mask = 32'h0;
        for (int i = 0; i < 4; i++)
            if (be[i]) mask = mask | (32'hFF << (8 * i));
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic logic [31:0] expRead(logic [4:0] a);
        logic [31:0] v;
        if (busyLeft > 0 || a == 5'd0) return 32'h0;
        v = mdl[a];
`ifdef GPR_BYPASS_EN
        if (reg_write && write_addr != 5'd0 && a == write_addr) v = merge(v, write_data, byte_en);
        if (flag_write && a == 5'(FLAGR)) v[0] = 1'b1;
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic zeroModel();
        for (int i = 0; i < NREGS; i++) mdl[i] = 32'h0;
    endtask

    // Check every output against the model, then cross one rising edge and advance the model.
    task automatic cycle();
        #1;
        if (known) begin
            for (int k = 0; k < NR; k++)
                chk("rd_port", rd_data[k*DW +: DW], expRead(rd_addr[k*AW +: AW]));
            chk("busy", {31'h0, busy}, {31'h0, busyLeft > 0});
            chk("wr_dropped", {31'h0, wr_dropped}, {31'h0, dropExp});
        end
        @(posedge clk);
        if (!reset) begin
            busyLeft = NREGS - 1;
            dropExp  = 1'b0;
            known    = 1'b1;
            zeroModel();
        end else if (busyLeft > 0) begin
            dropExp = reg_write || flag_write;
            if (clr_req) busyLeft = NREGS - 1;
            else busyLeft--;
        end else begin
            dropExp = 1'b0;
            if (clr_req) begin
                busyLeft = NREGS - 1;
                zeroModel();
            end else begin
                if (reg_write && write_addr != 5'd0)
                    mdl[write_addr] = merge(mdl[write_addr], write_data, byte_en);
                if (flag_write) mdl[FLAGR][0] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        reg_write  = 1'b1;
        write_addr = a;
        write_data = d;
        byte_en    = be;
        cycle();
        reg_write  = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0; reg_write = 1'b0; byte_en = 4'h0; write_addr = 5'd0;
        write_data = 32'h0; flag_write = 1'b0; clr_req = 1'b0; rd_addr = 10'h0;

        cycle();
        cycle();
        reset = 1'b1;

        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            cycle();
        end
        chk("busy_len_reset", 32'(n), 32'd31);

        for (int a = 0; a < NREGS; a++) begin
            rd_addr = {5'(NREGS - 1 - a), 5'(a)};
            #1;
            chk("clear_rd0", rd_data[31:0], 32'h0);
            chk("clear_rd1", rd_data[63:32], 32'h0);
            cycle();
        end

        wr(5'd2, 32'h12345678, 4'hF);
        wr(5'd3, 32'h87654321, 4'hF);
        rd_addr = {5'd3, 5'd2};
        #1;
        chk("r2_full", rd_data[31:0], 32'h12345678);
        chk("r3_full", rd_data[63:32], 32'h87654321);
        cycle();

        rd_addr = {5'd0, 5'd0};
        wr(5'd0, 32'hFFFFFFFF, 4'hF);
        #1;
        chk("r0_zero", rd_data[31:0], 32'h0);

        rd_addr = {5'd3, 5'd2};
        wr(5'd2, 32'hAABBCCDD, 4'b0101);
        #1;
        chk("r2_bytes", rd_data[31:0], 32'h12BB56DD);
        wr(5'd2, 32'hFFFFFFFF, 4'h0);
        #1;
        chk("r2_be_zero", rd_data[31:0], 32'h12BB56DD);

        rd_addr    = {5'd2, 5'd30};
        flag_write = 1'b1;
        wr(5'd30, 32'hFFFF0000, 4'hF);
        flag_write = 1'b0;
        #1;
        chk("flag_and_write", rd_data[31:0], 32'hFFFF0001);
        wr(5'd30, 32'h0, 4'hF);
        flag_write = 1'b1;
        cycle();
        flag_write = 1'b0;
        #1;
        chk("flag_alone", rd_data[31:0], 32'h00000001);

        rd_addr    = {5'd2, 5'd7};
        reg_write  = 1'b1;
        write_addr = 5'd7;
        write_data = 32'hDEADBEEF;
        byte_en    = 4'hF;
        #1;
`ifdef GPR_BYPASS_EN
        chk("bypass_same_cycle", rd_data[31:0], 32'hDEADBEEF);
`else
        chk("no_bypass_same_cycle", rd_data[31:0], 32'h0);
`endif
        cycle();
        reg_write = 1'b0;
        #1;
        chk("r7_after_edge", rd_data[31:0], 32'hDEADBEEF);

        rd_addr = {5'd2, 5'd5};
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        #1;
        chk("clr_busy", {31'h0, busy}, 32'h1);
        wr(5'd5, 32'h0BADF00D, 4'hF);
        #1;
        chk("wr_dropped_pulse", {31'h0, wr_dropped}, 32'h1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            cycle();
        end
        chk("busy_len_clr", 32'(n), 32'd30);
        #1;
        chk("r5_dropped", rd_data[31:0], 32'h0);
        chk("r2_cleared", rd_data[63:32], 32'h0);
        chk("wr_dropped_low", {31'h0, wr_dropped}, 32'h0);

        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 249) != 0);
            clr_req    = ($urandom_range(0, 59) == 0);
            reg_write  = ($urandom_range(0, 2) != 0);
            flag_write = ($urandom_range(0, 7) == 0);
            write_addr = 5'($urandom_range(0, NREGS - 1));
            write_data = $urandom;
            byte_en    = 4'($urandom_range(0, 15));
            rd_addr    = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) rd_addr[4:0] = write_addr;
            if ($urandom_range(0, 5) == 0) rd_addr[9:5] = 5'(FLAGR);
            cycle();
        end
        reset = 1'b1; reg_write = 1'b0; flag_write = 1'b0; clr_req = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
